traffic_phase_sequencer: RTL and testbench

- Controller FSM directly upstream of the saturation counter: drives its rst/up/down/load/loadMax/maxIn/in inputs and consumes its count output as the phase timer.
- Sequences a two-way intersection (NS/EW) through green, yellow and all-red phases, plus an optional pedestrian WALK phase.
- Drives one-hot light outputs for each direction and a walk lamp.

---
 rtl/tlc_pkg.sv | 34 +++
 rtl/tlc_light_decode.sv | 28 ++
 rtl/traffic_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and encodings for the traffic phase sequencer.
// Holds the phase/step enumerations, the one-hot light encodings and the
// one-hot loadMax command values sent to the saturation counter.
package tlc_pkg;

  // Intersection phases; INIT is only occupied during and just after reset.
  typedef enum logic [2:0] {
    PH_INIT      = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_ALLRED_A  = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_ALLRED_B  = 3'd6,
    PH_WALK      = 3'd7
  } phase_t;

  // Every phase is a one-cycle preload of the timer followed by a countdown.
  typedef enum logic {
    STEP_LD  = 1'b0,
    STEP_RUN = 1'b1
  } step_t;

  // Lamp encodings, {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Counter loadMax commands. 00 would clear the counter's max register,
  // so the sequencer only ever drives one of these two.
  localparam logic [1:0] LM_LOAD = 2'b10;
  localparam logic [1:0] LM_HOLD = 2'b01;

endpackage

// File: rtl/tlc_light_decode.sv
// Combinational decode of the current phase into the two direction lamps
// and the pedestrian walk lamp. Anything not explicitly green or yellow is
// red, so unknown or reset phases fail safe to all-red.
module tlc_light_decode
  import tlc_pkg::*;
(
  input  phase_t     phase_i,
  output logic [2:0] ns_light_o,
  output logic [2:0] ew_light_o,
  output logic       ped_walk_o
);

  // Phase to lamp mapping; at most one direction leaves red in any phase.
  always_comb begin
    ns_light_o = RED;
    ew_light_o = RED;
    ped_walk_o = 1'b0;
    case (phase_i)
      PH_NS_GREEN:  ns_light_o = GRN;
      PH_NS_YELLOW: ns_light_o = YEL;
      PH_EW_GREEN:  ew_light_o = GRN;
      PH_EW_YELLOW: ew_light_o = YEL;
      PH_WALK:      ped_walk_o = 1'b1;
      default:      ;
    endcase
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-way intersection phase sequencer driving an external saturation
// counter as its phase timer. Each phase preloads the counter with TIME-2
// (LD step) and counts down to zero (RUN step), giving exactly TIME cycles.
// Optional build macro TLC_EW_SENSOR_EN adds an ew_car input; when no EW car
// has been seen, the EW green/yellow/all-red phases are skipped.
module traffic_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int COUNT_SIZE  = 5,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ped_req,
`ifdef TLC_EW_SENSOR_EN
  input  logic                  ew_car,
`endif
  input  logic [COUNT_SIZE-1:0] cnt_out,
  output logic                  cnt_rst,
  output logic                  cnt_up,
  output logic                  cnt_down,
  output logic                  cnt_load,
  output logic [1:0]            cnt_load_max,
  output logic [COUNT_SIZE-1:0] cnt_max,
  output logic [COUNT_SIZE-1:0] cnt_in,
  output logic [2:0]            ns_light,
  output logic [2:0]            ew_light,
  output logic                  ped_walk
);

  // Preload values: the LD cycle plus (TIME-1) RUN cycles down to zero.
  localparam logic [COUNT_SIZE-1:0] GREEN_LD  = COUNT_SIZE'(GREEN_TIME - 2);
  localparam logic [COUNT_SIZE-1:0] YELLOW_LD = COUNT_SIZE'(YELLOW_TIME - 2);
  localparam logic [COUNT_SIZE-1:0] ALLRED_LD = COUNT_SIZE'(ALLRED_TIME - 2);
  localparam logic [COUNT_SIZE-1:0] WALK_LD   = COUNT_SIZE'(WALK_TIME - 2);

  phase_t phase_q, phase_d;
  step_t  step_q, step_d;
  logic   ped_pending_q, ped_pending_d;
  logic   in_walk_ld;
`ifdef TLC_EW_SENSOR_EN
  logic   ew_pending_q, ew_pending_d;
  logic   in_ew_green_ld;
`endif

  // Timer preload for a given phase.
  function automatic logic [COUNT_SIZE-1:0] phase_load(input phase_t p);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:   return GREEN_LD;
      PH_NS_YELLOW, PH_EW_YELLOW: return YELLOW_LD;
      PH_ALLRED_A, PH_ALLRED_B:   return ALLRED_LD;
      PH_WALK:                    return WALK_LD;
      default:                    return '0;
    endcase
  endfunction

  assign in_walk_ld = (phase_q == PH_WALK) && (step_q == STEP_LD);
`ifdef TLC_EW_SENSOR_EN
  assign in_ew_green_ld = (phase_q == PH_EW_GREEN) && (step_q == STEP_LD);
`endif

  // Next phase/step and request latches; a new request in the clearing
  // cycle wins so it is served in the following rotation.
  always_comb begin
    phase_d       = phase_q;
    step_d        = step_q;
    ped_pending_d = ped_req | (ped_pending_q & ~in_walk_ld);
`ifdef TLC_EW_SENSOR_EN
    ew_pending_d  = ew_car | (ew_pending_q & ~in_ew_green_ld);
`endif
    if (phase_q == PH_INIT) begin
      phase_d = PH_NS_GREEN;
      step_d  = STEP_LD;
    end else if (step_q == STEP_LD) begin
      // cnt_out is stale here (the load lands at this edge), so ignore it.
      step_d = STEP_RUN;
    end else if (cnt_out == '0) begin
      step_d = STEP_LD;
      case (phase_q)
        PH_NS_GREEN:  phase_d = PH_NS_YELLOW;
        PH_NS_YELLOW: phase_d = PH_ALLRED_A;
`ifdef TLC_EW_SENSOR_EN
        PH_ALLRED_A:  phase_d = ew_pending_q  ? PH_EW_GREEN :
                                ped_pending_q ? PH_WALK : PH_NS_GREEN;
`else
        PH_ALLRED_A:  phase_d = PH_EW_GREEN;
`endif
        PH_EW_GREEN:  phase_d = PH_EW_YELLOW;
        PH_EW_YELLOW: phase_d = PH_ALLRED_B;
        PH_ALLRED_B:  phase_d = ped_pending_q ? PH_WALK : PH_NS_GREEN;
        default:      phase_d = PH_NS_GREEN;
      endcase
    end
  end

  // State registers; reset parks in INIT with all requests dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= PH_INIT;
      step_q        <= STEP_LD;
      ped_pending_q <= 1'b0;
`ifdef TLC_EW_SENSOR_EN
      ew_pending_q  <= 1'b0;
`endif
    end else begin
      phase_q       <= phase_d;
      step_q        <= step_d;
      ped_pending_q <= ped_pending_d;
`ifdef TLC_EW_SENSOR_EN
      ew_pending_q  <= ew_pending_d;
`endif
    end
  end

  // Counter control decoded from the registered state; INIT resets the
  // count and programs max to all ones, afterwards max is only held.
  always_comb begin
    cnt_rst      = 1'b0;
    cnt_down     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_max = LM_HOLD;
    cnt_max      = '1;
    cnt_in       = '0;
    if (phase_q == PH_INIT) begin
      cnt_rst      = 1'b1;
      cnt_load_max = LM_LOAD;
    end else if (step_q == STEP_LD) begin
      cnt_load = 1'b1;
      cnt_in   = phase_load(phase_q);
    end else begin
      cnt_down = 1'b1;
    end
  end

  assign cnt_up = 1'b0;

  tlc_light_decode u_light_decode (
    .phase_i    (phase_q),
    .ns_light_o (ns_light),
    .ew_light_o (ew_light),
    .ped_walk_o (ped_walk)
  );

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a behavioural saturation
// counter attached. Expected lamp sequences are kept as a table of
// {lamps, length, ped_req, ew_car} segments walked cycle by cycle.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       ped_req;
`ifdef TLC_EW_SENSOR_EN
  logic       ew_car;
`endif
  logic [4:0] cnt_out;
  logic       cnt_rst, cnt_up, cnt_down, cnt_load;
  logic [1:0] cnt_load_max;
  logic [4:0] cnt_max, cnt_in;
  logic [2:0] ns_light, ew_light;
  logic       ped_walk;

  logic [4:0] cnt_q;
  logic [4:0] max_q;

  int checks   = 0;
  int failures = 0;
  bit inv_en   = 1'b0;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    int         len;
    logic       ped;
    logic       car;
  } seg_t;

  seg_t tbl[$];

  always #5 clk = ~clk;

  traffic_phase_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .ped_req      (ped_req),
`ifdef TLC_EW_SENSOR_EN
    .ew_car       (ew_car),
`endif
    .cnt_out      (cnt_out),
    .cnt_rst      (cnt_rst),
    .cnt_up       (cnt_up),
    .cnt_down     (cnt_down),
    .cnt_load     (cnt_load),
    .cnt_load_max (cnt_load_max),
    .cnt_max      (cnt_max),
    .cnt_in       (cnt_in),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .ped_walk     (ped_walk)
  );

  // Saturation counter model: sync reset, load clipped to max, saturating
  // up/down, loadMax 10 = load max, 01 = hold, otherwise max clears.
  always_ff @(posedge clk) begin
    case (cnt_load_max)
      2'b10:   max_q <= cnt_max;
      2'b01:   max_q <= max_q;
      default: max_q <= '0;
    endcase
    if (cnt_rst)                          cnt_q <= '0;
    else if (cnt_load)                    cnt_q <= (cnt_in > max_q) ? max_q : cnt_in;
    else if (cnt_down && cnt_q != 5'd0)   cnt_q <= cnt_q - 5'd1;
    else if (cnt_up && cnt_q != max_q)    cnt_q <= cnt_q + 5'd1;
  end
  assign cnt_out = cnt_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [2:0] ns, input logic [2:0] ew, input logic walk,
                              input int len, input logic ped, input logic car);
    seg_t s;
    s.ns = ns; s.ew = ew; s.walk = walk; s.len = len; s.ped = ped; s.car = car;
    tbl.push_back(s);
  endfunction

  // One full rotation after an NS green of first_green cycles.
  function automatic void add_rest(input logic walk, input logic ped, input logic car);
    add(Y, R, 1'b0, 4, ped, car);
    add(R, R, 1'b0, 2, ped, car);
    add(R, G, 1'b0, 20, ped, car);
    add(R, Y, 1'b0, 4, ped, car);
    add(R, R, 1'b0, 2, ped, car);
    if (walk) add(R, R, 1'b1, 8, ped, car);
  endfunction

  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      for (int c = 0; c < tbl[i].len; c++) begin
        @(posedge clk);
        #1;
        ped_req = tbl[i].ped;
`ifdef TLC_EW_SENSOR_EN
        ew_car = tbl[i].car;
`endif
        @(negedge clk);
        chk($sformatf("seg%0d_cyc%0d", i, c), {25'd0, ns_light, ew_light, ped_walk},
            {25'd0, tbl[i].ns, tbl[i].ew, tbl[i].walk});
      end
    end
  endtask

  // Reset-state outputs, valid while rst is high.
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_lamps"}, {25'd0, ns_light, ew_light, ped_walk}, {25'd0, R, R, 1'b0});
    chk({tag, "_cnt_rst"}, {31'd0, cnt_rst}, 32'd1);
    chk({tag, "_load_max"}, {30'd0, cnt_load_max}, 32'd2);
  endtask

  // Release reset and check INIT, the NS green LD cycle and first RUN cycle.
  task automatic release_and_check(input string tag);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk({tag, "_init_lamps"}, {25'd0, ns_light, ew_light, ped_walk}, {25'd0, R, R, 1'b0});
    chk({tag, "_init_cnt_rst"}, {31'd0, cnt_rst}, 32'd1);
    chk({tag, "_init_max"}, {27'd0, cnt_max}, 32'd31);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_ld_lamps"}, {25'd0, ns_light, ew_light, ped_walk}, {25'd0, G, R, 1'b0});
    chk({tag, "_ld_load"}, {31'd0, cnt_load}, 32'd1);
    chk({tag, "_ld_in"}, {27'd0, cnt_in}, 32'd18);
    chk({tag, "_ld_load_max"}, {30'd0, cnt_load_max}, 32'd1);
    chk({tag, "_ld_down"}, {31'd0, cnt_down}, 32'd0);
    chk({tag, "_ld_cnt_rst"}, {31'd0, cnt_rst}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_run_lamps"}, {25'd0, ns_light, ew_light, ped_walk}, {25'd0, G, R, 1'b0});
    chk({tag, "_run_down"}, {31'd0, cnt_down}, 32'd1);
    chk({tag, "_run_load"}, {31'd0, cnt_load}, 32'd0);
    chk({tag, "_run_cnt"}, {27'd0, cnt_out}, 32'd18);
  endtask

  // Per-cycle safety and counter-command sanity.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("safety_both_nonred", {31'd0, (ns_light != R) && (ew_light != R)}, 32'd0);
      chk("load_max_nonzero", {31'd0, cnt_load_max == 2'b00}, 32'd0);
      chk("cnt_up_tied", {31'd0, cnt_up}, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_free, e_free, s_pulse, e_pulse, s_held, e_held, s_pre, e_pre, s_rs, e_rs;
`ifdef TLC_EW_SENSOR_EN
    int s_sen, e_sen;
`endif
    rst = 1'b1;
    ped_req = 1'b0;
`ifdef TLC_EW_SENSOR_EN
    ew_car = 1'b1;
`endif

    // Free run: first green is 18 because two cycles are checked by hand.
    s_free = tbl.size();
    add(G, R, 1'b0, 18, 1'b0, 1'b1); add_rest(1'b0, 1'b0, 1'b1);
    add(G, R, 1'b0, 20, 1'b0, 1'b1); add_rest(1'b0, 1'b0, 1'b1);
    e_free = tbl.size() - 1;
    // One-cycle pedestrian pulse during NS green, then a plain period.
    s_pulse = tbl.size();
    add(G, R, 1'b0, 5, 1'b0, 1'b1);
    add(G, R, 1'b0, 1, 1'b1, 1'b1);
    add(G, R, 1'b0, 14, 1'b0, 1'b1); add_rest(1'b1, 1'b0, 1'b1);
    add(G, R, 1'b0, 20, 1'b0, 1'b1); add_rest(1'b0, 1'b0, 1'b1);
    e_pulse = tbl.size() - 1;
    // Held request: set survives the WALK.LD clear, so the next period walks too.
    s_held = tbl.size();
    add(G, R, 1'b0, 20, 1'b1, 1'b1); add_rest(1'b1, 1'b1, 1'b1);
    add(G, R, 1'b0, 20, 1'b0, 1'b1); add_rest(1'b1, 1'b0, 1'b1);
    add(G, R, 1'b0, 20, 1'b0, 1'b1); add_rest(1'b0, 1'b0, 1'b1);
    e_held = tbl.size() - 1;
    // Lead-in to the async reset: a pending request, then part of EW green.
    s_pre = tbl.size();
    add(G, R, 1'b0, 3, 1'b0, 1'b1);
    add(G, R, 1'b0, 1, 1'b1, 1'b1);
    add(G, R, 1'b0, 16, 1'b0, 1'b1);
    add(Y, R, 1'b0, 4, 1'b0, 1'b1);
    add(R, R, 1'b0, 2, 1'b0, 1'b1);
    add(R, G, 1'b0, 5, 1'b0, 1'b1);
    e_pre = tbl.size() - 1;
    // After the restart the dropped request must not produce a WALK.
    s_rs = tbl.size();
    add(G, R, 1'b0, 18, 1'b0, 1'b1); add_rest(1'b0, 1'b0, 1'b1);
    add(G, R, 1'b0, 20, 1'b0, 1'b1);
    e_rs = tbl.size() - 1;
`ifdef TLC_EW_SENSOR_EN
    // ew_car low: one period drains the old latch, then 26-cycle periods;
    // a pulse during NS green brings the EW phases back once.
    s_sen = tbl.size();
    add_rest(1'b0, 1'b0, 1'b0);
    add(G, R, 1'b0, 20, 1'b0, 1'b0); add(Y, R, 1'b0, 4, 1'b0, 1'b0); add(R, R, 1'b0, 2, 1'b0, 1'b0);
    add(G, R, 1'b0, 20, 1'b0, 1'b0); add(Y, R, 1'b0, 4, 1'b0, 1'b0); add(R, R, 1'b0, 2, 1'b0, 1'b0);
    add(G, R, 1'b0, 5, 1'b0, 1'b0);
    add(G, R, 1'b0, 1, 1'b0, 1'b1);
    add(G, R, 1'b0, 14, 1'b0, 1'b0); add_rest(1'b0, 1'b0, 1'b0);
    add(G, R, 1'b0, 20, 1'b0, 1'b0); add(Y, R, 1'b0, 4, 1'b0, 1'b0); add(R, R, 1'b0, 2, 1'b0, 1'b0);
    add(G, R, 1'b0, 1, 1'b0, 1'b0);
    e_sen = tbl.size() - 1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    inv_en = 1'b1;

    release_and_check("rel1");
    run_segs(s_free, e_free);
    run_segs(s_pulse, e_pulse);
    run_segs(s_held, e_held);
    run_segs(s_pre, e_pre);

    // Asynchronous reset between edges in the middle of EW green.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
    release_and_check("rel2");
    run_segs(s_rs, e_rs);
`ifdef TLC_EW_SENSOR_EN
    run_segs(s_sen, e_sen);
`endif

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
